// File: rtl/lif_neuron_core.sv
// Single leaky integrate-and-fire neuron: saturating 6-bit membrane, programmable
// leak period and threshold, one-cycle spike followed by a fixed refractory window.
module lif_neuron_core #(
    parameter int VW        = 6,
    parameter int WW        = 3,
    parameter int REFRAC    = 2,
    parameter int THRES_RST = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [WW-1:0] i_wspike,
    input  logic          i_svalid,
    input  logic [3:0]    i_State,
    input  logic          i_recc,
    input  logic [VW-1:0] i_Thres,
    input  logic          i_Thres_valid,
    output logic [VW-1:0] o_V,
    output logic          o_spike
);

    typedef enum logic [0:0] {
        ST_INTEG = 1'b0,
        ST_REFR  = 1'b1
    } state_t;

    localparam logic [VW-1:0] V_ZERO     = {VW{1'b0}};
    localparam logic [VW-1:0] V_ONE      = {{(VW-1){1'b0}}, 1'b1};
    localparam logic [VW-1:0] V_MAX      = {VW{1'b1}};
    localparam logic [VW-1:0] THRES_INIT = VW'(THRES_RST);
    localparam logic [3:0]    REFRAC_LD  = 4'(REFRAC);

    // Unsigned add clamped at full scale.
    function automatic logic [VW-1:0] sat_add(input logic [VW-1:0] v, input logic [WW-1:0] w);
        logic [VW:0] sum_s;
        sum_s = {1'b0, v} + {1'b0, {(VW-WW){1'b0}}, w};
        if (sum_s[VW]) begin
            return V_MAX;
        end else begin
            return sum_s[VW-1:0];
        end
    endfunction

    // Unsigned subtract clamped at zero.
    function automatic logic [VW-1:0] sat_sub(input logic [VW-1:0] v, input logic [WW-1:0] w);
        logic [VW-1:0] w_ext_s;
        w_ext_s = {{(VW-WW){1'b0}}, w};
        if (v >= w_ext_s) begin
            return v - w_ext_s;
        end else begin
            return V_ZERO;
        end
    endfunction

    state_t        state_r;
    logic [VW-1:0] v_r;
    logic          spike_r;
    logic [3:0]    ref_cnt_r;
    logic [VW-1:0] thres_r;
    logic [3:0]    leak_cnt_r;

    logic          tick_s;
    logic [3:0]    leak_nxt_s;
    logic [VW-1:0] va_s;
    logic [VW-1:0] vn_s;
    logic          fire_s;

    // Leak tick: >= rather than == so a shortened period ticks at once instead of wrapping.
    always_comb begin
        tick_s     = 1'b0;
        leak_nxt_s = 4'd0;
        if (i_State == 4'd0) begin
            tick_s     = 1'b0;
            leak_nxt_s = 4'd0;
        end else if (leak_cnt_r >= (i_State - 4'd1)) begin
            tick_s     = 1'b1;
            leak_nxt_s = 4'd0;
        end else begin
            tick_s     = 1'b0;
            leak_nxt_s = leak_cnt_r + 4'd1;
        end
    end

    // Integration datapath: input event first, then leak, then threshold compare.
    always_comb begin
        va_s   = v_r;
        vn_s   = v_r;
        fire_s = 1'b0;
        if (i_svalid) begin
            if (i_recc) begin
                va_s = sat_sub(v_r, i_wspike);
            end else begin
                va_s = sat_add(v_r, i_wspike);
            end
        end else begin
            va_s = v_r;
        end
        if (tick_s && (va_s != V_ZERO)) begin
            vn_s = va_s - V_ONE;
        end else begin
            vn_s = va_s;
        end
        if ((state_r == ST_INTEG) && (thres_r != V_ZERO) && (vn_s >= thres_r)) begin
            fire_s = 1'b1;
        end else begin
            fire_s = 1'b0;
        end
    end

    // Leak counter runs regardless of integrate/refractory state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leak_cnt_r <= 4'd0;
        end else begin
            leak_cnt_r <= leak_nxt_s;
        end
    end

    // Threshold register; the same-cycle fire compare still sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thres_r <= THRES_INIT;
        end else if (i_Thres_valid) begin
            thres_r <= i_Thres;
        end else begin
            thres_r <= thres_r;
        end
    end

    // Integrate / refractory FSM with registered potential and spike.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_INTEG;
            v_r       <= V_ZERO;
            spike_r   <= 1'b0;
            ref_cnt_r <= 4'd0;
        end else begin
            case (state_r)
                ST_INTEG: begin
                    if (fire_s) begin
                        v_r       <= V_ZERO;
                        spike_r   <= 1'b1;
                        ref_cnt_r <= REFRAC_LD;
                        state_r   <= ST_REFR;
                    end else begin
                        v_r       <= vn_s;
                        spike_r   <= 1'b0;
                        ref_cnt_r <= 4'd0;
                        state_r   <= ST_INTEG;
                    end
                end
                ST_REFR: begin
                    v_r     <= V_ZERO;
                    spike_r <= 1'b0;
                    if (ref_cnt_r <= 4'd1) begin
                        ref_cnt_r <= 4'd0;
                        state_r   <= ST_INTEG;
                    end else begin
                        ref_cnt_r <= ref_cnt_r - 4'd1;
                        state_r   <= ST_REFR;
                    end
                end
                default: begin
                    v_r       <= V_ZERO;
                    spike_r   <= 1'b0;
                    ref_cnt_r <= 4'd0;
                    state_r   <= ST_INTEG;
                end
            endcase
        end
    end

    assign o_V     = v_r;
    assign o_spike = spike_r;

    lif_neuron_core_chk #(
        .VW(VW)
    ) u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .v       (v_r),
        .spike   (spike_r),
        .in_refr (state_r == ST_REFR)
    );

endmodule

// Invariant checker for the neuron core outputs.
module lif_neuron_core_chk #(
    parameter int VW = 6
) (
    input logic          clk,
    input logic          rst_n,
    input logic [VW-1:0] v,
    input logic          spike,
    input logic          in_refr
);

    a_spike_clears_v : assert property (@(posedge clk) disable iff (!rst_n) spike |-> (v == {VW{1'b0}}));
    a_no_back_to_back : assert property (@(posedge clk) disable iff (!rst_n) spike |=> !spike);
    a_refr_holds_zero : assert property (@(posedge clk) disable iff (!rst_n) in_refr |-> (v == {VW{1'b0}}));

endmodule

// File: tb/tb_lif_neuron_core.sv
// Self-checking bench for lif_neuron_core: directed scenarios plus a randomized run
// checked against an integer-arithmetic reference model.
module tb_lif_neuron_core;

    localparam int VW        = 6;
    localparam int WW        = 3;
    localparam int REFRAC    = 2;
    localparam int THRES_RST = 32;
    localparam int VMAX      = 63;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [WW-1:0] i_wspike;
    logic          i_svalid;
    logic [3:0]    i_State;
    logic          i_recc;
    logic [VW-1:0] i_Thres;
    logic          i_Thres_valid;
    logic [VW-1:0] o_V;
    logic          o_spike;

    int n_cmp = 0;
    int n_bad = 0;

    int m_v;
    int m_thres;
    int m_leak;
    int m_refr;
    bit m_spike;

    lif_neuron_core #(
        .VW(VW), .WW(WW), .REFRAC(REFRAC), .THRES_RST(THRES_RST)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_wspike      (i_wspike),
        .i_svalid      (i_svalid),
        .i_State       (i_State),
        .i_recc        (i_recc),
        .i_Thres       (i_Thres),
        .i_Thres_valid (i_Thres_valid),
        .o_V           (o_V),
        .o_spike       (o_spike)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_v     = 0;
        m_thres = THRES_RST;
        m_leak  = 0;
        m_refr  = 0;
        m_spike = 0;
    endtask

    // One clock of neuron behaviour in plain integer arithmetic.
    task automatic model_step();
        int p;
        int a;
        bit tick;
        p    = int'(i_State);
        tick = 0;
        if (p == 0) m_leak = 0;
        else if (m_leak >= p - 1) begin tick = 1; m_leak = 0; end
        else m_leak = m_leak + 1;
        m_spike = 0;
        if (m_refr > 0) begin
            m_refr = m_refr - 1;
            m_v    = 0;
        end else begin
            a = m_v;
            if (i_svalid) begin
                if (i_recc) a = (a - int'(i_wspike) < 0) ? 0 : a - int'(i_wspike);
                else        a = (a + int'(i_wspike) > VMAX) ? VMAX : a + int'(i_wspike);
            end
            if (tick && a > 0) a = a - 1;
            if (m_thres != 0 && a >= m_thres) begin
                m_v = 0; m_spike = 1; m_refr = REFRAC;
            end else begin
                m_v = a;
            end
        end
        if (i_Thres_valid) m_thres = int'(i_Thres);
    endtask

    task automatic set_in(input bit sv, input int w, input bit recc);
        i_svalid      = sv;
        i_wspike      = WW'(w);
        i_recc        = recc;
        i_Thres_valid = 1'b0;
    endtask

    task automatic drive_cycle();
        @(posedge clk);
        model_step();
        #1;
        i_Thres_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(0, 0, 0);
        i_State = 4'd0;
        i_Thres = 6'd0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (o_V !== 6'd0 || o_spike !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got V=%0d spike=%0d want V=0 spike=0", o_V, o_spike);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_excite_refractory();
        int exp_v[8] = '{7, 14, 21, 28, 0, 0, 0, 7};
        bit exp_s[8] = '{0, 0, 0, 0, 1, 0, 0, 0};
        for (int k = 0; k < 8; k++) begin
            set_in(1, 7, 0);
            drive_cycle();
            n_cmp++;
            if (o_V !== 6'(exp_v[k]) || o_spike !== exp_s[k]) begin
                n_bad++;
                $display("FAIL excite_evt%0d: got V=%0d spike=%0d want V=%0d spike=%0d",
                         k + 1, o_V, o_spike, exp_v[k], exp_s[k]);
            end
        end
    endtask

    task automatic test_inhibit();
        int exp_v[3] = '{10, 3, 0};
        for (int k = 0; k < 3; k++) begin
            if (k == 0) set_in(1, 3, 0);
            else        set_in(1, 7, 1);
            drive_cycle();
            n_cmp++;
            if (o_V !== 6'(exp_v[k]) || o_spike !== 1'b0) begin
                n_bad++;
                $display("FAIL inhibit_step%0d: got V=%0d spike=%0d want V=%0d spike=0",
                         k, o_V, o_spike, exp_v[k]);
            end
        end
    endtask

    task automatic test_saturate();
        int e;
        set_in(0, 0, 0);
        i_Thres = 6'd0; i_Thres_valid = 1'b1;
        drive_cycle();
        for (int k = 1; k <= 10; k++) begin
            set_in(1, 7, 0);
            drive_cycle();
            e = (7 * k > VMAX) ? VMAX : 7 * k;
            n_cmp++;
            if (o_V !== 6'(e) || o_spike !== 1'b0) begin
                n_bad++;
                $display("FAIL saturate_up%0d: got V=%0d spike=%0d want V=%0d spike=0", k, o_V, o_spike, e);
            end
        end
        for (int k = 1; k <= 10; k++) begin
            set_in(1, 7, 1);
            drive_cycle();
            e = (VMAX - 7 * k < 0) ? 0 : VMAX - 7 * k;
            n_cmp++;
            if (o_V !== 6'(e)) begin
                n_bad++;
                $display("FAIL saturate_down%0d: got V=%0d want V=%0d", k, o_V, e);
            end
        end
        set_in(0, 0, 0);
        i_Thres = 6'd32; i_Thres_valid = 1'b1;
        drive_cycle();
    endtask

    task automatic test_leak();
        int e;
        int exp_v[3] = '{4, 4, 3};
        i_State = 4'd0;
        set_in(1, 5, 0);
        drive_cycle();
        i_State = 4'd4;
        for (int k = 1; k <= 24; k++) begin
            set_in(0, 0, 0);
            drive_cycle();
            e = (5 - k / 4 < 0) ? 0 : 5 - k / 4;
            n_cmp++;
            if (o_V !== 6'(e)) begin
                n_bad++;
                $display("FAIL leak_p4_cyc%0d: got V=%0d want V=%0d", k, o_V, e);
            end
        end
        set_in(1, 5, 0);
        drive_cycle();
        set_in(0, 0, 0);
        repeat (2) drive_cycle();
        n_cmp++;
        if (o_V !== 6'd5) begin
            n_bad++;
            $display("FAIL leak_preload: got V=%0d want V=5", o_V);
        end
        i_State = 4'd2;
        for (int k = 0; k < 3; k++) begin
            drive_cycle();
            n_cmp++;
            if (o_V !== 6'(exp_v[k])) begin
                n_bad++;
                $display("FAIL leak_p2_cyc%0d: got V=%0d want V=%0d", k, o_V, exp_v[k]);
            end
        end
        i_State = 4'd0;
    endtask

    task automatic test_thres_load();
        int exp_v[16] = '{8, 13, 0, 0, 0, 5, 0, 0, 0, 7, 14, 21, 26, 0, 0, 0};
        bit exp_s[16] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        int w_tab[16] = '{5, 5, 0, 5, 5, 5, 5, 0, 0, 7, 7, 7, 5, 7, 0, 0};
        for (int k = 0; k < 14; k++) begin
            set_in(w_tab[k] != 0, w_tab[k], 0);
            if (k == 1 || k == 13) begin i_Thres = 6'd10; i_Thres_valid = 1'b1; end
            if (k == 7)            begin i_Thres = 6'd32; i_Thres_valid = 1'b1; end
            drive_cycle();
            n_cmp++;
            if (o_V !== 6'(exp_v[k]) || o_spike !== exp_s[k]) begin
                n_bad++;
                $display("FAIL thres_load_step%0d: got V=%0d spike=%0d want V=%0d spike=%0d",
                         k, o_V, o_spike, exp_v[k], exp_s[k]);
            end
        end
    endtask

    task automatic test_reset_in_refr();
        set_in(0, 0, 0);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (o_V !== 6'd0 || o_spike !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset_refr: got V=%0d spike=%0d want V=0 spike=0", o_V, o_spike);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        set_in(1, 3, 0);
        drive_cycle();
        n_cmp++;
        if (o_V !== 6'd3 || o_spike !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_event: got V=%0d spike=%0d want V=3 spike=0", o_V, o_spike);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            set_in($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 24) == 0) i_State = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) begin
                i_Thres       = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
                i_Thres_valid = 1'b1;
            end
            drive_cycle();
            n_cmp++;
            if (o_V !== 6'(m_v) || o_spike !== m_spike) begin
                n_bad++;
                $display("FAIL random_cyc%0d: got V=%0d spike=%0d want V=%0d spike=%0d",
                         k, o_V, o_spike, m_v, m_spike);
            end
        end
    endtask

    initial begin
        test_reset();
        test_excite_refractory();
        test_inhibit();
        test_saturate();
        test_leak();
        test_thres_load();
        test_reset_in_refr();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
